// File: rtl/afifo_stream_pkg.sv
// Shared parameters and helpers for the async FIFO pop-side stream logic.
package afifo_stream_pkg;

  // Local buffer must hold every word that can be in flight plus the one being presented.
  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

  // The 36K FIFO primitive only supports these read port widths.
  function automatic bit width_allowed(input int unsigned width);
    return (width == 9) || (width == 18) || (width == 36);
  endfunction

endpackage

// File: rtl/afifo_pop_buf.sv
// Small circular buffer that holds captured FIFO words until the stream accepts them.
module afifo_pop_buf #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned OCC_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock0,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic                  do_wr, do_rd;

  // DEPTH need not be a power of two, so wrap by compare-and-reset.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign do_wr    = wr_en & ~flush;
  assign do_rd    = rd_en & (occ_q != '0);
  assign occ      = occ_q;
  assign rd_valid = (occ_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a flush empties the buffer regardless of traffic.
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_wr && !do_rd) begin
        occ_d = occ_q + OCC_WIDTH'(1);
      end else if (!do_wr && do_rd) begin
        occ_d = occ_q - OCC_WIDTH'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage is deliberately not reset.
  always_ff @(posedge clock0) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/afifo_pop_stream.sv
// Pop-side consumer for the async FIFO: credit-limited prefetch onto a valid/ready stream.
module afifo_pop_stream
  import afifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock0,
  input  logic                  reset_n,
  input  logic                  Empty,
  input  logic                  Underrun_Error,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  POP,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  err_sticky
);
  localparam int unsigned Depth = buf_depth(RD_LATENCY);
  localparam int unsigned OccW  = $clog2(Depth + 1);
  localparam int unsigned PendW = $clog2(Depth + RD_LATENCY + 1) + 1;

  if (!width_allowed(DATA_WIDTH)) begin : g_bad_width
    $error("afifo_pop_stream: DATA_WIDTH must be 9, 18 or 36");
  end
  if ((RD_LATENCY < 1) || (RD_LATENCY > 2)) begin : g_bad_latency
    $error("afifo_pop_stream: RD_LATENCY must be 1 or 2");
  end

  logic [RD_LATENCY-1:0] inflt_q, inflt_d;
  logic [RD_LATENCY-1:0] disc_q, disc_d;
  logic [OccW-1:0]       occ;
  logic [PendW-1:0]      pending;
  logic [CNT_WIDTH-1:0]  word_count_q;
  logic                  err_q;
  logic                  deq, capture, pop;

  assign deq        = m_valid & m_ready;
  assign capture    = inflt_q[RD_LATENCY-1] & ~disc_q[RD_LATENCY-1];
  assign word_count = word_count_q;
  assign err_sticky = err_q;

  // Credit: words held plus words still travelling through the FIFO read pipeline.
  always_comb begin
    pending = PendW'(occ);
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      pending = pending + PendW'(inflt_q[i]);
    end
  end

  // Pop only when a slot is guaranteed; a same-cycle dequeue frees one.
  always_comb begin
    pop = ~Empty & (pending < (PendW'(Depth) + PendW'(deq))) & ~flush & reset_n;
    POP = pop;
  end

  // Track pops in flight; flush tags them so they are dropped on arrival.
  always_comb begin
    inflt_d = (inflt_q << 1) | RD_LATENCY'(pop);
    disc_d  = (disc_q | (flush ? inflt_q : '0)) << 1;
  end

  // In-flight and discard shift registers.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      inflt_q <= '0;
      disc_q  <= '0;
    end else begin
      inflt_q <= inflt_d;
      disc_q  <= disc_d;
    end
  end

  // Delivered-word counter (wraps) and sticky underrun latch.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (deq) word_count_q <= word_count_q + CNT_WIDTH'(1);
      if (Underrun_Error) err_q <= 1'b1;
    end
  end

  afifo_pop_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (Depth),
    .OCC_WIDTH  (OccW)
  ) u_buf (
    .clock0   (clock0),
    .reset_n  (reset_n),
    .flush    (flush),
    .wr_en    (capture),
    .wr_data  (DOUT),
    .rd_en    (deq),
    .occ      (occ),
    .rd_valid (m_valid),
    .rd_data  (m_data)
  );

endmodule
